nibble_add_seq: RTL and testbench

//  Sequenced multi-nibble adder controller. Adds two NIBBLES*4-bit operands with one

---
 rtl/nibble_add_seq_pkg.sv | 13 +
 rtl/nibble_add_seq_adder.sv | 26 ++
 rtl/nibble_add_seq.sv | 129 ++++++++++++
 tb/tb_nibble_add_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_add_seq_pkg.sv
// Shared definitions for the sequenced nibble adder: nibble width and FSM state encodings.
// Encoding 2'd3 is unreachable and is decoded as IDLE by the controller.
package nibble_add_seq_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_add_seq_adder.sv
// Purely combinational 4-bit ripple adder slice shared by every nibble of the operation.
// Exposes both the carry into bit 3 and the carry out, so the controller can form overflow.
module nibble_adder
   import nibble_add_seq_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                ci,
   output logic [NIBBLE_W-1:0] s,
   output logic                c3,
   output logic                c4
);

   logic [NIBBLE_W-1:0] low_sum;
   logic [1:0]          top_sum;

   // Add the low three bits first to expose the carry into bit 3, then finish the MSB.
   always_comb begin
      low_sum = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, ci};
      c3      = low_sum[3];
      top_sum = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, low_sum[3]};
      c4      = top_sum[1];
      s       = {top_sum[0], low_sum[2:0]};
   end

endmodule

// File: rtl/nibble_add_seq.sv
// Sequenced multi-nibble adder: one shared 4-bit adder, LS nibble first, one nibble per clock.
// Optional feature macro: NIBBLE_ADD_SUB_EN adds the sub port (a-b via inverted b and carry 1).
module nibble_add_seq
   import nibble_add_seq_pkg::*;
#(
   parameter int NIBBLES = 4,
   localparam int W = NIBBLE_W * NIBBLES
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
`ifdef NIBBLE_ADD_SUB_EN
   input  logic         sub,
`endif
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t              state;
   state_t              next_state;
   logic [IDX_W-1:0]    idx;
   logic [W-1:0]        a_q;
   logic [W-1:0]        b_q;
   logic                carry_q;
   logic                accept;
   logic [NIBBLE_W-1:0] nib_a;
   logic [NIBBLE_W-1:0] nib_b;
   logic [NIBBLE_W-1:0] nib_s;
   logic                nib_c3;
   logic                nib_c4;
   logic [W-1:0]        b_in;
   logic                carry_in;

   assign accept = (state == ST_IDLE) && start;
   assign nib_a  = a_q[idx*NIBBLE_W +: NIBBLE_W];
   assign nib_b  = b_q[idx*NIBBLE_W +: NIBBLE_W];

   // Choose the operand B image and initial carry that get latched on accept.
`ifdef NIBBLE_ADD_SUB_EN
   always_comb begin
      b_in     = sub ? ~b : b;
      carry_in = sub ? 1'b1 : cin;
   end
`else
   always_comb begin
      b_in     = b;
      carry_in = cin;
   end
`endif

   nibble_adder u_adder (
      .a  (nib_a),
      .b  (nib_b),
      .ci (carry_q),
      .s  (nib_s),
      .c3 (nib_c3),
      .c4 (nib_c4)
   );

   // State register; reset aborts any operation in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and status decode; the unused encoding falls back to IDLE.
   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) next_state = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (idx == LAST_IDX) next_state = ST_DONE;
         end
         ST_DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            next_state = ST_IDLE;
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Operand latch on accept, then one nibble of result and carry per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= b_in;
         carry_q <= carry_in;
         idx     <= '0;
         sum     <= '0;
      end else if (state == ST_RUN) begin
         sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_s;
         carry_q                       <= nib_c4;
         idx                           <= idx + IDX_W'(1);
         if (idx == LAST_IDX) begin
            cout <= nib_c4;
            ovf  <= nib_c3 ^ nib_c4;
         end
      end
   end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (NIBBLES=4) against an arithmetic reference model.
// Define NIBBLE_ADD_SUB_EN for both bench and RTL to exercise the subtract feature.
module tb_nibble_add_seq;

   localparam int NIBBLES = 4;
   localparam int W = 4 * NIBBLES;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int tests_run;
   int tests_failed;

   nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef NIBBLE_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout),
      .ovf   (ovf)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Reference model: exact integer sum/difference, signed range test for overflow.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                        input logic msub, output logic [W-1:0] es, output logic ec, output logic eo);
      logic [W:0] full;
      longint sa, sb, sr;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      if (msub) begin
         full = {1'b0, ma} + {1'b0, ~mb} + (W+1)'(1);
         sr   = sa - sb;
      end else begin
         full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
         sr   = sa + sb + longint'(mcin);
      end
      es = full[W-1:0];
      ec = full[W];
      eo = (sr > (longint'(1) <<< (W-1)) - 1) || (sr < -(longint'(1) <<< (W-1)));
   endtask

   // Run one operation from an IDLE negedge; optionally pulse start (with junk a) at cycle T+inject.
   task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                         input logic osub, input int inject);
      logic [W-1:0] es;
      logic         ec, eo;
      model(oa, ob, ocin, osub, es, ec, eo);
      a = oa; b = ob; cin = ocin; sub = osub; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= NIBBLES + 2; k++) begin
         @(negedge clk);
         check_output($sformatf("busy@T+%0d", k), 64'(busy), 64'(k <= NIBBLES + 1));
         check_output($sformatf("done@T+%0d", k), 64'(done), 64'(k == NIBBLES + 1));
         if (k == NIBBLES + 1 || k == NIBBLES + 2) begin
            check_output("sum", 64'(sum), 64'(es));
            check_output("cout", 64'(cout), 64'(ec));
            check_output("ovf", 64'(ovf), 64'(eo));
         end
         a = W'($urandom);
         b = W'($urandom);
         cin = 1'($urandom);
         if (k == inject) begin
            start = 1'b1;
            a = 16'hAAAA;
         end else begin
            start = 1'b0;
         end
      end
   endtask

   // Drop reset during RUN and confirm the abort clears outputs with no done pulse.
   task automatic reset_mid_op(input logic [W-1:0] oa, input logic [W-1:0] ob);
      a = oa; b = ob; cin = 1'b0; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_output("rst busy", 64'(busy), 64'(0));
      check_output("rst done", 64'(done), 64'(0));
      check_output("rst sum", 64'(sum), 64'(0));
      check_output("rst cout", 64'(cout), 64'(0));
      check_output("rst ovf", 64'(ovf), 64'(0));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_output("rst no done", 64'(done), 64'(0));
      end
      rst_n = 1'b1;
      for (int k = 0; k < NIBBLES + 2; k++) begin
         @(negedge clk);
         check_output("post rst idle done", 64'(done), 64'(0));
         check_output("post rst idle busy", 64'(busy), 64'(0));
      end
   endtask

   // Stimulus: reset, directed cases, reset abort, randomized operations.
   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst_n = 1'b0;
      start = 1'b0;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      check_output("reset busy", 64'(busy), 64'(0));
      check_output("reset done", 64'(done), 64'(0));
      check_output("reset sum", 64'(sum), 64'(0));
      check_output("reset cout", 64'(cout), 64'(0));
      check_output("reset ovf", 64'(ovf), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
      check_output("dir 5555", 64'(sum), 64'h5555);
      run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
      check_output("dir ripple", 64'({cout, sum}), 64'h10000);
      run_op(16'hFFFF, 16'h0001, 1'b1, 1'b0, 0);
      check_output("dir ripple cin", 64'({cout, sum}), 64'h10001);
      run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
      check_output("dir ovf", 64'({ovf, cout, sum}), 64'h28000);
      run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 2);
      check_output("dir busy start", 64'(sum), 64'h0002);
      run_op(16'h0003, 16'h0004, 1'b0, 1'b0, NIBBLES + 1);
      check_output("dir done start", 64'(sum), 64'h0007);

      reset_mid_op(16'h1111, 16'h2222);
      run_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 0);
      check_output("after rst", 64'(sum), 64'h1000);

`ifdef NIBBLE_ADD_SUB_EN
      run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
      check_output("sub neg", 64'({cout, sum}), 64'h0FFFE);
      run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
      check_output("sub ovf", 64'({ovf, sum}), 64'h17FFF);
`endif

      for (int i = 0; i < 25; i++) begin
         int inj;
         logic rs;
         inj = $urandom_range(0, 3);
         if (inj == 3) inj = NIBBLES + 1;
`ifdef NIBBLE_ADD_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         run_op(W'($urandom), W'($urandom), 1'($urandom), rs, inj);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation exceeded time limit");
      $fatal(1, "[TB] timeout");
   end

endmodule
